// File: rtl/spi_sensor_slave.sv
// SPI mode-3 slave exposing a 64x8 sensor register file; the host side updates
// registers directly and is notified of every committed SPI write.
module spi_sensor_slave #(
    parameter logic [7:0] WHO_AM_I = 8'hD3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO,
    input  logic       sample_valid,
    input  logic [5:0] sample_addr,
    input  logic [7:0] sample_data,
    output logic       wr_valid,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t     state, state_next;
    logic [1:0] sclk_sync, mosi_sync, ss_sync;
    logic       sclk_d, ss_d;
    logic       sclk_s, mosi_s, ss_s;
    logic       sclk_rise, sclk_fall, ss_fall;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in, out_sh, in_byte;
    logic       miso_r, rw, ms;
    logic [5:0] addr, addr_next;
    logic       cmd_done, byte_done;
    logic [7:0] regs [64];

    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign ss_s      = ss_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign in_byte   = {shift_in[6:0], mosi_s};
    assign addr_next = ms ? addr + 6'd1 : addr;
    assign busy      = (state != IDLE);
    assign MISO      = miso_r & rw & (state == DATA);

    function automatic logic [7:0] rd_reg(input logic [5:0] a);
        return (a == 6'h0F) ? WHO_AM_I : regs[a];
    endfunction

    // Synchronizers reset low so an SS held low across reset shows no falling
    // edge: the slave stays idle until SS is released and asserted again.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            ss_sync   <= {ss_sync[0], SS};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_done   = 1'b0;
        byte_done  = 1'b0;
        case (state)
            IDLE: if (ss_fall) state_next = CMD;
            CMD: begin
                if (ss_s) state_next = IDLE;
                else if (sclk_rise && bit_cnt == 3'd7) begin
                    cmd_done   = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (ss_s) state_next = IDLE;
                else if (sclk_rise && bit_cnt == 3'd7) byte_done = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift_in <= '0;
            out_sh   <= '0;
            miso_r   <= 1'b0;
            rw       <= 1'b0;
            ms       <= 1'b0;
            addr     <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            // Host update first so a same-cycle SPI commit below overrides it.
            if (sample_valid) regs[sample_addr] <= sample_data;
            if (state == IDLE) begin
                if (ss_fall) begin
                    bit_cnt  <= '0;
                    shift_in <= '0;
                    out_sh   <= '0;
                    miso_r   <= 1'b0;
                end
            end else if (!ss_s && sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= in_byte;
                if (cmd_done) begin
                    rw     <= in_byte[7];
                    ms     <= in_byte[6];
                    addr   <= in_byte[5:0];
                    out_sh <= rd_reg(in_byte[5:0]);
                end
                if (byte_done) begin
                    if (!rw && addr != 6'h0F) begin
                        regs[addr] <= in_byte;
                        wr_valid   <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= in_byte;
                    end
                    addr   <= addr_next;
                    out_sh <= rd_reg(addr_next);
                end
            end else if (state == DATA && !ss_s && sclk_fall && rw) begin
                miso_r <= out_sh[7];
                out_sh <= {out_sh[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_sensor_slave.sv
// Scoreboard bench: SPI master tasks push expected read bytes and write
// notifications; monitors pop and compare as the DUT produces them.
module tb_spi_sensor_slave;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SCLK = 1'b1;
    logic       MOSI = 1'b0;
    logic       SS = 1'b1;
    logic       MISO;
    logic       sample_valid = 1'b0;
    logic [5:0] sample_addr = '0;
    logic [7:0] sample_data = '0;
    logic       wr_valid;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_rd[$];
    logic [7:0]  obs_rd[$];
    logic [13:0] exp_wr[$];

    spi_sensor_slave #(.WHO_AM_I(8'hD3)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .sample_valid(sample_valid), .sample_addr(sample_addr), .sample_data(sample_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-data monitor
    always @(negedge clk) begin
        if (obs_rd.size() > 0) begin
            logic [7:0] o;
            o = obs_rd.pop_front();
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got %0h expected none", o);
            end else chk("rd_byte", {24'h0, o}, {24'h0, exp_rd.pop_front()});
        end
    end

    // Write-notification monitor
    always @(negedge clk) begin
        if (!reset && wr_valid) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected none", wr_addr, wr_data);
            end else chk("wr_notify", {18'h0, wr_addr, wr_data}, {18'h0, exp_wr.pop_front()});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ss_low();
        @(negedge clk); SS = 1'b0;
        wait_clk(6);
    endtask

    task automatic ss_high();
        @(negedge clk); SS = 1'b1;
        wait_clk(8);
    endtask

    // Sends the first nbits of tx MSB-first; optionally records the MISO byte
    // and optionally fires sample_valid in the commit cycle of the last bit.
    task automatic spi_byte(input logic [7:0] tx, input bit rec, input bit col, input int nbits);
        logic [7:0] rx;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); SCLK = 1'b0; MOSI = tx[7-i];
            wait_clk(6);
            rx = {rx[6:0], MISO};
            SCLK = 1'b1;
            if (col && i == nbits - 1) begin
                @(posedge clk); @(posedge clk);
                #1 sample_valid = 1'b1;
                @(posedge clk);
                #1 sample_valid = 1'b0;
                wait_clk(4);
            end else wait_clk(5);
        end
        if (rec) obs_rd.push_back(rx);
    endtask

    task automatic spi_read(input logic [7:0] cmd, input int n);
        ss_low();
        spi_byte(cmd, 1'b0, 1'b0, 8);
        for (int i = 0; i < n; i++) spi_byte(8'h00, 1'b1, 1'b0, 8);
        ss_high();
    endtask

    task automatic sample_wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        sample_valid = 1'b1; sample_addr = a; sample_data = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        wait_clk(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_miso", {31'h0, MISO}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("rst_wr_addr", {26'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        wait_clk(4);

        // Register cleared by reset; ID register
        exp_rd.push_back(8'h00); spi_read(8'h85, 1);
        exp_rd.push_back(8'hD3); spi_read(8'h8F, 1);

        // Burst write with auto-increment, then burst readback
        exp_wr.push_back({6'h20, 8'hA1});
        exp_wr.push_back({6'h21, 8'hB2});
        ss_low();
        spi_byte(8'h60, 1'b0, 1'b0, 8);
        spi_byte(8'hA1, 1'b0, 1'b0, 8);
        spi_byte(8'hB2, 1'b0, 1'b0, 8);
        ss_high();
        exp_rd.push_back(8'hA1); exp_rd.push_back(8'hB2); spi_read(8'hE0, 2);

        // Auto-increment wraps 3F -> 00
        sample_wr(6'h3F, 8'h11);
        sample_wr(6'h00, 8'h22);
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); spi_read(8'hFF, 2);

        // Non-increment read repeats the same register
        sample_wr(6'h28, 8'h5C);
        for (int i = 0; i < 3; i++) exp_rd.push_back(8'h5C);
        spi_read(8'hA8, 3);

        // Abort after 5 data bits: no commit, idle quickly
        ss_low();
        spi_byte(8'h20, 1'b0, 1'b0, 8);
        spi_byte(8'hFF, 1'b0, 1'b0, 5);
        @(negedge clk); SS = 1'b1;
        wait_clk(4);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        wait_clk(4);
        exp_rd.push_back(8'hA1); spi_read(8'hA0, 1);

        // SPI write and host update to the same register in the same cycle
        sample_addr = 6'h10; sample_data = 8'h33;
        exp_wr.push_back({6'h10, 8'h77});
        ss_low();
        spi_byte(8'h10, 1'b0, 1'b0, 8);
        spi_byte(8'h77, 1'b0, 1'b1, 8);
        ss_high();
        exp_rd.push_back(8'h77); spi_read(8'h90, 1);

        // Write to ID address is dropped silently
        ss_low();
        spi_byte(8'h0F, 1'b0, 1'b0, 8);
        spi_byte(8'h55, 1'b0, 1'b0, 8);
        ss_high();
        exp_rd.push_back(8'hD3); spi_read(8'h8F, 1);

        // Reset mid-transaction: remaining SPI traffic ignored until next SS fall
        ss_low();
        spi_byte(8'h60, 1'b0, 1'b0, 8);
        spi_byte(8'hA5, 1'b0, 1'b0, 3);
        @(negedge clk); reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        spi_byte(8'h5A, 1'b0, 1'b0, 8);
        spi_byte(8'hC3, 1'b0, 1'b0, 8);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        ss_high();
        exp_rd.push_back(8'h00); exp_rd.push_back(8'h00); spi_read(8'hE0, 2);
        exp_rd.push_back(8'hD3); spi_read(8'h8F, 1);

        wait_clk(10);
        chk("rd_pending", exp_rd.size(), 32'h0);
        chk("wr_pending", exp_wr.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
